// File: rtl/uart_tx_fifo_drain_if.sv
// uart_tx_fifo_drain_if: FIFO read side, frame config and serial outputs of the UART TX drain
interface uart_tx_fifo_drain_if #(parameter int DATA_WIDTH = 8);
    logic                  R_EMPTY;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  R_INC;
    logic                  TX_OUT;
    logic                  BUSY;
    modport master (output R_EMPTY, RD_DATA, PAR_EN, PAR_TYP, input R_INC, TX_OUT, BUSY);
    modport slave (input R_EMPTY, RD_DATA, PAR_EN, PAR_TYP, output R_INC, TX_OUT, BUSY);
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops FIFO words and serializes them as UART frames, one bit per CLK
module uart_tx_fifo_drain #(
    parameter int DATA_WIDTH = 8
) (
    input logic                    CLK,
    input logic                    RST,
    uart_tx_fifo_drain_if.slave    bus
);
    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic                  pen_q, pen_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  pop;
    logic                  last_bit;
    assign pop = !RST && !bus.R_EMPTY && (state_q == IDLE || state_q == STOP);
    assign last_bit = cnt_q == CW'(DATA_WIDTH - 1);
    assign bus.R_INC = pop;
    assign bus.TX_OUT = tx_q;
    assign bus.BUSY = busy_q;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            pen_q   <= pen_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pop ? START : IDLE;
            START:   state_d = DATA;
            DATA:    state_d = last_bit ? (pen_q ? PARITY : STOP) : DATA;
            PARITY:  state_d = STOP;
            STOP:    state_d = pop ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end
    // TX_OUT is registered from the state being entered, so bit i leaves on the edge entering it
    always_comb begin
        cnt_d  = (state_q == DATA && !last_bit) ? cnt_q + CW'(1) : '0;
        sh_d   = pop ? bus.RD_DATA : (state_d == DATA ? sh_q >> 1 : sh_q);
        pen_d  = pop ? bus.PAR_EN : pen_q;
        par_d  = pop ? (^bus.RD_DATA) ^ bus.PAR_TYP : par_q;
        tx_d   = state_d == START ? 1'b0 :
                 state_d == DATA ? sh_q[0] :
                 state_d == PARITY ? par_q : 1'b1;
        busy_d = state_d != IDLE;
    end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: per-cycle vector table plus hand sequences for back-to-back, config and reset cases
module tb_uart_tx_fifo_drain;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) bus();
    uart_tx_fifo_drain #(.DATA_WIDTH(8)) dut (.CLK(clk), .RST(rst), .bus(bus.slave));
    typedef struct {
        logic       rst;
        logic       re;
        logic [7:0] d;
        logic       pe;
        logic       pt;
        logic       rinc;
        logic       tx;
        logic       busy;
    } vec_t;
    vec_t tbl[$];
    int passed = 0;
    int total = 0;
    int rinc_cnt = 0;
    function automatic void add(logic r, logic re, logic [7:0] d, logic pe, logic pt,
                                logic rinc, logic tx, logic busy);
        vec_t v;
        v.rst = r; v.re = re; v.d = d; v.pe = pe; v.pt = pt;
        v.rinc = rinc; v.tx = tx; v.busy = busy;
        tbl.push_back(v);
    endfunction
    // expected line level j cycles after the pop (j=1 is the start bit)
    function automatic logic frame_tx(logic [7:0] d, logic pe, logic pt, int j);
        if (j == 1) return 1'b0;
        if (j <= 9) return d[j-2];
        if (pe && j == 10) return (^d) ^ pt;
        return 1'b1;
    endfunction
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    task automatic apply(string name, logic r, logic re, logic [7:0] d, logic pe, logic pt,
                         logic rinc, logic tx, logic busy);
        @(posedge clk);
        #1;
        rst = r; bus.R_EMPTY = re; bus.RD_DATA = d; bus.PAR_EN = pe; bus.PAR_TYP = pt;
        @(negedge clk);
        if (bus.R_INC === 1'b1) rinc_cnt++;
        chk({name, " r_inc"}, {31'd0, bus.R_INC}, {31'd0, rinc});
        chk({name, " tx_out"}, {31'd0, bus.TX_OUT}, {31'd0, tx});
        chk({name, " busy"}, {31'd0, bus.BUSY}, {31'd0, busy});
    endtask
    initial begin
        logic [9:0] a5_line;
        a5_line = 10'b1101001010;
        rst = 1'b1; bus.R_EMPTY = 1'b1; bus.RD_DATA = '0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) add(1, 1, 8'h00, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) add(0, 1, 8'h00, 0, 0, 0, 1, 0);
        add(0, 0, 8'hA5, 0, 0, 1, 1, 0);
        for (int j = 1; j <= 10; j++) add(0, 1, 8'hA5, 0, 0, 0, a5_line[j-1], 1);
        add(0, 1, 8'h00, 0, 0, 0, 1, 0);
        for (int t = 0; t < 2; t++) begin
            add(0, 0, 8'h07, 1, t[0], 1, 1, 0);
            for (int j = 1; j <= 11; j++) add(0, 1, 8'h07, 1, t[0], 0, frame_tx(8'h07, 1, t[0], j), 1);
            add(0, 1, 8'h00, 0, 0, 0, 1, 0);
        end
        foreach (tbl[i]) apply($sformatf("tbl[%0d]", i), tbl[i].rst, tbl[i].re, tbl[i].d,
                               tbl[i].pe, tbl[i].pt, tbl[i].rinc, tbl[i].tx, tbl[i].busy);
        // back-to-back frames: second pop lands in the stop cycle
        rinc_cnt = 0;
        apply("b2b pop1", 0, 0, 8'h55, 0, 0, 1, 1, 0);
        for (int j = 1; j <= 9; j++) apply($sformatf("b2b f1.%0d", j), 0, 0, 8'h0F, 0, 0, 0, frame_tx(8'h55, 0, 0, j), 1);
        apply("b2b stop/pop2", 0, 0, 8'h0F, 0, 0, 1, 1, 1);
        for (int j = 1; j <= 10; j++) apply($sformatf("b2b f2.%0d", j), 0, 1, 8'h00, 0, 0, 0, frame_tx(8'h0F, 0, 0, j), 1);
        apply("b2b idle", 0, 1, 8'h00, 0, 0, 0, 1, 0);
        chk("b2b r_inc pulses", rinc_cnt, 2);
        // PAR_EN dropped mid-frame only affects the next frame
        apply("cfg pop1", 0, 0, 8'h3C, 1, 0, 1, 1, 0);
        for (int j = 1; j <= 11; j++) apply($sformatf("cfg f1.%0d", j), 0, 1, 8'h00, j < 3, 0, 0, frame_tx(8'h3C, 1, 0, j), 1);
        apply("cfg idle1", 0, 1, 8'h00, 0, 0, 0, 1, 0);
        apply("cfg pop2", 0, 0, 8'h3C, 0, 0, 1, 1, 0);
        for (int j = 1; j <= 10; j++) apply($sformatf("cfg f2.%0d", j), 0, 1, 8'h00, 0, 0, 0, frame_tx(8'h3C, 0, 0, j), 1);
        apply("cfg idle2", 0, 1, 8'h00, 0, 0, 0, 1, 0);
        // reset during the 4th data bit aborts the frame
        rinc_cnt = 0;
        apply("rst pop", 0, 0, 8'hFF, 0, 0, 1, 1, 0);
        for (int j = 1; j <= 4; j++) apply($sformatf("rst f.%0d", j), 0, 0, 8'hAA, 0, 0, 0, frame_tx(8'hFF, 0, 0, j), 1);
        apply("rst assert", 1, 0, 8'hAA, 0, 0, 0, 1, 1);
        apply("rst held", 1, 0, 8'hAA, 0, 0, 0, 1, 0);
        chk("rst no r_inc", rinc_cnt, 1);
        apply("rst release pop", 0, 0, 8'h81, 0, 0, 1, 1, 0);
        for (int j = 1; j <= 10; j++) apply($sformatf("rst f2.%0d", j), 0, 1, 8'h00, 0, 0, 0, frame_tx(8'h81, 0, 0, j), 1);
        apply("rst idle", 0, 1, 8'h00, 0, 0, 0, 1, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
